race_out_capture: RTL and testbench

//  Sink for RACE_top complex output: captures in_real/in_imag once per strobe into an on-chip buffer.

---
 rtl/race_out_capture_pkg.sv | 31 +++
 rtl/race_out_capture_fifo.sv | 114 +++++++++++
 rtl/race_out_capture.sv | 224 ++++++++++++++++++++++
 tb/tb_race_out_capture.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/race_out_capture_pkg.sv
// ---------------------------------------------------------------------------
// race_out_capture_pkg
// Shared definitions for the RACE_top output capture block.
//
// Contents
//   cap_state_t  : capture controller states (IDLE, SKIP, CAPT, DONE)
//   DEF_W        : default bits per real/imag sample
//   is_armable() : true in the states where a start pulse re-arms the
//                  capture (IDLE and DONE)
// ---------------------------------------------------------------------------
package race_out_capture_pkg;

    // Capture controller states. The numeric values are kept stable so a
    // state value probed in hardware can be read back directly.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SKIP = 2'd1,
        ST_CAPT = 2'd2,
        ST_DONE = 2'd3
    } cap_state_t;

    // Default sample width of the filter output.
    localparam int DEF_W = 16;

    // A start pulse is honoured only from a quiescent state. A start that
    // arrives while skipping or capturing is ignored.
    function automatic logic is_armable(input cap_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/race_out_capture_fifo.sv
// ---------------------------------------------------------------------------
// race_out_capture_fifo
// First-word-fall-through synchronous FIFO holding complex samples
// {real, imag}. The head entry is presented on o_rd_data one cycle after it
// is written. When the FIFO runs empty, o_rd_data keeps the last value it
// showed.
//
// Parameters
//   W2     : entry width (2*W for a complex sample)
//   DEPTH  : number of entries, power of two, at least 2
//
// Ports
//   i_clk      in   1            system clock
//   i_rst      in   1            synchronous reset, active-high (flushes)
//   i_wr_en    in   1            write request
//   i_wr_data  in   W2           write data
//   o_full     out  1            DEPTH entries stored
//   i_rd_en    in   1            pop request (ignored when empty)
//   o_rd_data  out  W2           head entry (held when empty)
//   o_empty    out  1            no entries stored
//   o_level    out  log2(DEPTH)+1 number of entries stored
// ---------------------------------------------------------------------------
module race_out_capture_fifo
    import race_out_capture_pkg::*;
#(
    parameter int W2    = 2 * DEF_W,
    parameter int DEPTH = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [W2-1:0]            i_wr_data,
    output logic                     o_full,
    input  logic                     i_rd_en,
    output logic [W2-1:0]            o_rd_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W2-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [W2-1:0] r_rd_data;

    logic          w_pop;
    logic          w_push;
    logic [AW-1:0] w_rd_ptr_next;

    // A pop frees a slot in the same cycle, so a write to a full FIFO is
    // still accepted when it coincides with a pop.
    assign w_pop         = i_rd_en & (r_count != '0);
    assign w_push        = i_wr_en & ((r_count != FULL_CNT) | w_pop);
    assign w_rd_ptr_next = r_rd_ptr + AW'(1);

    // Storage array. It has no reset: emptiness is tracked by r_count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers and occupancy. Pointers wrap naturally at DEPTH because
    // DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

    // Head register for fall-through reads. The head changes only when the
    // FIFO was empty and gets a write, or when the head is popped. A pop of
    // the last entry with no write leaves the old value showing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (r_count == '0) begin
            if (w_push) begin
                r_rd_data <= i_wr_data;
            end
        end else if (w_pop) begin
            if (r_count == (AW + 1)'(1)) begin
                if (w_push) begin
                    r_rd_data <= i_wr_data;
                end
            end else begin
                r_rd_data <= r_mem[w_rd_ptr_next];
            end
        end
    end

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_level   = r_count;
    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/race_out_capture.sv
// ---------------------------------------------------------------------------
// race_out_capture
// Sink for the RACE_top complex output. It captures {in_real, in_imag} once
// per sample strobe into an on-chip FIFO, so filter output can be checked in
// hardware. The FIFO drains over a valid/ready read port that works in every
// state. After a start pulse, the block discards SKIP_N strobe edges while
// the filter settles. It then captures cap_len samples. A sample that meets
// a full buffer is dropped and sets the sticky ovf flag.
//
// Parameters
//   W      : bits per real/imag sample (signed, stored raw)
//   DEPTH  : buffer entries, power of two
//   SKIP_N : strobe edges discarded after start (0 = none)
//   CNT_W  : width of cap_len and the capture counter
//
// Ports
//   i_clk       in   1               system clock
//   i_rst       in   1               synchronous reset, active-high
//   i_strobe    in   1               sample-rate strobe (level)
//   i_in_real   in   W               filter output, real part
//   i_in_imag   in   W               filter output, imag part
//   i_start     in   1               arm pulse, samples i_cap_len
//   i_abort     in   1               return to IDLE, buffer kept
//   i_cap_len   in   CNT_W           samples to capture after the skip
//   o_busy      out  1               skipping or capturing
//   o_done      out  1               capture finished
//   o_ovf       out  1               sticky: a capture hit a full buffer
//   o_rd_data   out  2*W             {real, imag} of oldest entry
//   o_rd_valid  out  1               o_rd_data valid
//   i_rd_ready  in   1               pop when o_rd_valid & i_rd_ready
//   o_level     out  log2(DEPTH)+1   entries stored
// ---------------------------------------------------------------------------
module race_out_capture
    import race_out_capture_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int DEPTH  = 1024,
    parameter int SKIP_N = 64,
    parameter int CNT_W  = 20
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_strobe,
    input  logic [W-1:0]             i_in_real,
    input  logic [W-1:0]             i_in_imag,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic [CNT_W-1:0]         i_cap_len,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_ovf,
    output logic [2*W-1:0]           o_rd_data,
    output logic                     o_rd_valid,
    input  logic                     i_rd_ready,
    output logic [$clog2(DEPTH):0]   o_level
);

    // Index of the last discarded edge. This value is unused when SKIP_N
    // is 0, because the SKIP state is never entered in that case.
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((SKIP_N > 0) ? (SKIP_N - 1) : 0);

    cap_state_t             r_state;
    cap_state_t             w_next_state;

    logic                   r_strobe_d;
    logic                   w_edge;
    logic [CNT_W-1:0]       r_skip_cnt;
    logic [CNT_W-1:0]       r_cap_cnt;
    logic [CNT_W-1:0]       r_cap_len;
    logic                   r_wr_pend;
    logic [2*W-1:0]         r_sample;
    logic                   r_ovf;

    logic                   w_start_go;
    logic                   w_skip_edge;
    logic                   w_cap_edge;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_drop;
    logic [$clog2(DEPTH):0] w_level;

    // Rising edge of the sample strobe. r_strobe_d resets to 1, so a strobe
    // that is already high when reset is released does not count as a sample.
    assign w_edge     = i_strobe & ~r_strobe_d;
    assign w_start_go = i_start & ~i_abort & is_armable(r_state);
    assign w_pop      = i_rd_ready & ~w_empty;

    // A latched sample that reaches a full FIFO with no pop in the same
    // cycle is lost. It still counts toward cap_len.
    assign w_drop     = r_wr_pend & w_full & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_strobe_d <= 1'b1;
        end else begin
            r_strobe_d <= i_strobe;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and status outputs. Abort has priority over everything,
    // including a start in the same cycle. The edge that completes the skip
    // window is consumed there and is not stored. A capture length of 0
    // goes to DONE without writing anything.
    always_comb begin
        w_next_state = r_state;
        w_skip_edge  = 1'b0;
        w_cap_edge   = 1'b0;
        o_busy       = (r_state == ST_SKIP) || (r_state == ST_CAPT);
        o_done       = (r_state == ST_DONE);

        if (i_abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        if (SKIP_N != 0) begin
                            w_next_state = ST_SKIP;
                        end else if (i_cap_len == '0) begin
                            w_next_state = ST_DONE;
                        end else begin
                            w_next_state = ST_CAPT;
                        end
                    end
                end
                ST_SKIP: begin
                    if (w_edge) begin
                        w_skip_edge = 1'b1;
                        if (r_skip_cnt == SKIP_LAST) begin
                            w_next_state = (r_cap_len == '0) ? ST_DONE : ST_CAPT;
                        end
                    end
                end
                ST_CAPT: begin
                    if (w_edge) begin
                        w_cap_edge = 1'b1;
                        if (r_cap_cnt == (r_cap_len - CNT_W'(1))) begin
                            w_next_state = ST_DONE;
                        end
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Skip and capture counters. A start clears both counters and loads the
    // capture length, so restarting from DONE begins a fresh run.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_skip_cnt <= '0;
            r_cap_cnt  <= '0;
            r_cap_len  <= '0;
        end else if (w_start_go) begin
            r_skip_cnt <= '0;
            r_cap_cnt  <= '0;
            r_cap_len  <= i_cap_len;
        end else begin
            if (w_skip_edge) begin
                r_skip_cnt <= r_skip_cnt + CNT_W'(1);
            end
            if (w_cap_edge) begin
                r_cap_cnt <= r_cap_cnt + CNT_W'(1);
            end
        end
    end

    // The sample is latched on the edge cycle and written on the next clock.
    // A latched write completes even if abort or DONE arrives in between.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_pend <= 1'b0;
            r_sample  <= '0;
        end else begin
            r_wr_pend <= w_cap_edge;
            if (w_cap_edge) begin
                r_sample <= {i_in_real, i_in_imag};
            end
        end
    end

    // Sticky overflow flag. A start clears it, so the flag reports only the
    // run that start begins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (w_start_go) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    race_out_capture_fifo #(
        .W2    (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (r_wr_pend),
        .i_wr_data (r_sample),
        .o_full    (w_full),
        .i_rd_en   (w_pop),
        .o_rd_data (o_rd_data),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    assign o_ovf      = r_ovf;
    assign o_rd_valid = ~w_empty;
    assign o_level    = w_level;

endmodule

// File: tb/tb_race_out_capture.sv
// ---------------------------------------------------------------------------
// tb_race_out_capture
// Directed bench for race_out_capture. dutA uses a small buffer (DEPTH=16)
// and a short settling skip (SKIP_N=4). A queue-based model predicts every
// output of dutA on every cycle. dutB (SKIP_N=0) covers the zero-length
// capture case.
// ---------------------------------------------------------------------------
module tb_race_out_capture;

    localparam int W     = 16;
    localparam int DEPTH = 16;
    localparam int SKIPN = 4;
    localparam int CNT_W = 20;

    localparam int P_IDLE = 0;
    localparam int P_SKIP = 1;
    localparam int P_CAPT = 2;
    localparam int P_DONE = 3;

    logic                 clk;
    logic                 rst;
    logic                 strobe;
    logic [W-1:0]         inReal;
    logic [W-1:0]         inImag;
    logic                 start;
    logic                 startB;
    logic                 abort;
    logic [CNT_W-1:0]     capLen;
    logic                 rdReady;

    logic                 busy, done, ovf, rdValid;
    logic [2*W-1:0]       rdData;
    logic [4:0]           level;
    logic                 busyB, doneB, ovfB, rdValidB;
    logic [2*W-1:0]       rdDataB;
    logic [4:0]           levelB;

    int checks = 0;
    int errors = 0;
    int sampleVal = 0;

    // Model state: expected FIFO contents and the capture phase.
    logic [31:0] mq[$];
    logic [31:0] mData     = '0;
    logic [31:0] mPendData = '0;
    bit          mPend     = 0;
    bit          mPrev     = 1;
    bit          mOvf      = 0;
    int          mPhase    = P_IDLE;
    int          mEdges    = 0;
    int          mCapt     = 0;
    int          mCapLen   = 0;

    race_out_capture #(.W(W), .DEPTH(DEPTH), .SKIP_N(SKIPN), .CNT_W(CNT_W)) dutA (
        .i_clk(clk), .i_rst(rst), .i_strobe(strobe), .i_in_real(inReal), .i_in_imag(inImag),
        .i_start(start), .i_abort(abort), .i_cap_len(capLen), .o_busy(busy), .o_done(done),
        .o_ovf(ovf), .o_rd_data(rdData), .o_rd_valid(rdValid), .i_rd_ready(rdReady), .o_level(level)
    );

    race_out_capture #(.W(W), .DEPTH(DEPTH), .SKIP_N(0), .CNT_W(CNT_W)) dutB (
        .i_clk(clk), .i_rst(rst), .i_strobe(strobe), .i_in_real(inReal), .i_in_imag(inImag),
        .i_start(startB), .i_abort(1'b0), .i_cap_len(capLen), .o_busy(busyB), .o_done(doneB),
        .o_ovf(ovfB), .o_rd_data(rdDataB), .o_rd_valid(rdValidB), .i_rd_ready(1'b0), .o_level(levelB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge. The model applies the block's
    // rules directly to a queue of stored words.
    task automatic modelStep();
        bit          pop;
        bit          edgeNow;
        bit          drop;
        bit          go;
        bit          newPend;
        logic [31:0] dummy;
        if (rst) begin
            mq.delete();
            mPrev = 1; mPhase = P_IDLE; mOvf = 0; mPend = 0; mData = '0;
            mEdges = 0; mCapt = 0; mCapLen = 0;
            return;
        end
        pop     = rdReady && (mq.size() > 0);
        edgeNow = strobe && !mPrev;
        mPrev   = strobe;
        drop    = 0;
        newPend = 0;
        if (pop) dummy = mq.pop_front();
        if (mPend) begin
            if (mq.size() < DEPTH) mq.push_back(mPendData);
            else drop = 1;
        end
        go = start && !abort && (mPhase == P_IDLE || mPhase == P_DONE);
        if (abort) begin
            mPhase = P_IDLE;
        end else if (go) begin
            mEdges = 0; mCapt = 0; mCapLen = int'(capLen);
            if (SKIPN == 0) mPhase = (mCapLen == 0) ? P_DONE : P_CAPT;
            else mPhase = P_SKIP;
        end else if (mPhase == P_SKIP && edgeNow) begin
            mEdges++;
            if (mEdges == SKIPN) mPhase = (mCapLen == 0) ? P_DONE : P_CAPT;
        end else if (mPhase == P_CAPT && edgeNow) begin
            newPend = 1;
            mPendData = {inReal, inImag};
            mCapt++;
            if (mCapt == mCapLen) mPhase = P_DONE;
        end
        if (go) mOvf = 0;
        else if (drop) mOvf = 1;
        mPend = newPend;
        if (mq.size() > 0) mData = mq[0];
    endtask

    task automatic compareAll();
        checkOutput("busy",     64'(busy),    64'(mPhase == P_SKIP || mPhase == P_CAPT));
        checkOutput("done",     64'(done),    64'(mPhase == P_DONE));
        checkOutput("ovf",      64'(ovf),     64'(mOvf));
        checkOutput("level",    64'(level),   64'(mq.size()));
        checkOutput("rd_valid", 64'(rdValid), 64'(mq.size() > 0));
        checkOutput("rd_data",  64'(rdData),  64'(mData));
    endtask

    // Model runs on each rising edge; outputs are compared on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            compareAll();
        end
    end

    // One strobe period per sample: high for 10 clocks, low for 10, with a
    // ramp value presented on the rise. Entered and left on a falling edge.
    task automatic applyStimulus(input int nStrobes);
        for (int i = 0; i < nStrobes; i++) begin
            sampleVal++;
            inReal = 16'(sampleVal);
            inImag = 16'(-sampleVal);
            strobe = 1'b1;
            repeat (10) @(negedge clk);
            strobe = 1'b0;
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic startPulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic abortPulse();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    function automatic logic [63:0] word(input int k);
        logic [15:0] re;
        logic [15:0] im;
        re = 16'(k);
        im = 16'(-k);
        return 64'({re, im});
    endfunction

    initial begin
        rst = 1'b1; strobe = 1'b0; inReal = '0; inImag = '0;
        start = 1'b0; startB = 1'b0; abort = 1'b0; capLen = '0; rdReady = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset busy",     64'(busy),    64'(0));
        checkOutput("reset level",    64'(level),   64'(0));
        checkOutput("reset rd_data",  64'(rdData),  64'(0));
        checkOutput("reset B done",   64'(doneB),   64'(0));

        // Skip 4 edges, then store ramp values 5..12.
        capLen = 20'd8; sampleVal = 0;
        startPulse();
        checkOutput("t1 busy after start", 64'(busy), 64'(1));
        applyStimulus(12);
        checkOutput("t1 done",  64'(done),  64'(1));
        checkOutput("t1 level", 64'(level), 64'(8));
        applyStimulus(8);
        checkOutput("t1 level after done", 64'(level), 64'(8));

        // Drain in order with ready held high.
        for (int k = 5; k <= 12; k++) begin
            rdReady = 1'b1;
            checkOutput("t2 rd_valid", 64'(rdValid), 64'(1));
            checkOutput("t2 rd_data",  64'(rdData),  word(k));
            @(negedge clk);
        end
        checkOutput("t2 rd_valid empty", 64'(rdValid), 64'(0));
        checkOutput("t2 level empty",    64'(level),   64'(0));
        checkOutput("t2 rd_data hold",   64'(rdData),  word(12));
        rdReady = 1'b0;

        // Overflow: 20 capture edges into 16 entries.
        capLen = 20'd20; sampleVal = 0;
        startPulse();
        applyStimulus(24);
        checkOutput("t3 level full", 64'(level),  64'(16));
        checkOutput("t3 ovf",        64'(ovf),    64'(1));
        checkOutput("t3 done",       64'(done),   64'(1));
        checkOutput("t3 head",       64'(rdData), word(5));

        // Pop in the same cycle as a write into the full buffer.
        capLen = 20'd1; sampleVal = 0;
        startPulse();
        checkOutput("t3 ovf cleared", 64'(ovf), 64'(0));
        applyStimulus(4);
        sampleVal++;
        inReal = 16'(sampleVal); inImag = 16'(-sampleVal);
        strobe = 1'b1;
        @(negedge clk);
        rdReady = 1'b1;
        @(negedge clk);
        rdReady = 1'b0;
        repeat (8) @(negedge clk);
        strobe = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("t3 level pop+write", 64'(level),  64'(16));
        checkOutput("t3 ovf pop+write",   64'(ovf),    64'(0));
        checkOutput("t3 head after pop",  64'(rdData), word(6));
        rdReady = 1'b1;
        repeat (20) @(negedge clk);
        rdReady = 1'b0;
        checkOutput("t3 flushed", 64'(level), 64'(0));

        // Abort after three stores.
        capLen = 20'd10; sampleVal = 0;
        startPulse();
        applyStimulus(7);
        repeat (2) @(negedge clk);
        abortPulse();
        checkOutput("t4 busy after abort",  64'(busy),  64'(0));
        checkOutput("t4 level after abort", 64'(level), 64'(3));
        applyStimulus(3);
        checkOutput("t4 level ignored", 64'(level), 64'(3));
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checkOutput("t4 start+abort busy", 64'(busy), 64'(0));

        // Reset mid-capture with the strobe high at release.
        capLen = 20'd10; sampleVal = 0;
        startPulse();
        applyStimulus(6);
        checkOutput("t5 level before rst", 64'(level), 64'(5));
        sampleVal++;
        inReal = 16'(sampleVal); inImag = 16'(-sampleVal);
        strobe = 1'b1; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5 busy",     64'(busy),    64'(0));
        checkOutput("t5 level",    64'(level),   64'(0));
        checkOutput("t5 rd_valid", 64'(rdValid), 64'(0));
        repeat (8) @(negedge clk);
        strobe = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("t5 level later", 64'(level), 64'(0));

        // Zero-length capture with no skip.
        capLen = '0;
        startB = 1'b1;
        @(negedge clk);
        startB = 1'b0;
        checkOutput("t6 done",     64'(doneB),    64'(1));
        checkOutput("t6 busy",     64'(busyB),    64'(0));
        checkOutput("t6 level",    64'(levelB),   64'(0));
        checkOutput("t6 rd_valid", 64'(rdValidB), 64'(0));
        checkOutput("t6 ovf",      64'(ovfB),     64'(0));
        checkOutput("t6 rd_data",  64'(rdDataB),  64'(0));
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
